// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Brief   : Packs a length-prefixed byte stream into 32-bit words and writes
//           them to program memory while holding the core in reset.
// Revision: 1.0
// ============================================================================
module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWrite,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        CPUHold,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam logic [16:0] MAX_LEN = 17'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_COLLECT = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [15:0] len_full;

  assign ByteReady = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_COLLECT);
  assign MemWrite  = (state_q == S_WRITE);
  assign xfer      = ByteValid & ByteReady;
  assign len_full  = {ByteIn, len_q[7:0]};

  // Address/data are forced to zero outside the write strobe so idle outputs stay quiet.
  assign WriteAddress = MemWrite ? (BASE_ADDR + {14'd0, word_idx_q, 2'b00}) : 32'd0;
  assign WriteData    = MemWrite ? word_q : 32'd0;
  assign CPUHold      = cpu_hold_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Error        = error_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    cpu_hold_d = cpu_hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d    = S_LEN_LO;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_idx_d = 16'd0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = ByteIn;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = ByteIn;
          if (len_full == 16'd0) begin
            state_d    = S_DONE;
            cpu_hold_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d    = S_COLLECT;
            byte_idx_d = 2'd0;
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = ByteIn;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (word_idx_q == len_q - 16'd1) begin
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          word_idx_d = word_idx_q + 16'd1;
          state_d    = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule
`default_nettype wire
